button_conditioner: RTL and testbench

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/button_conditioner.sv | 142 ++++++++++++++
 tb/tb_button_conditioner.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Button conditioner: per-channel 2-flop sync, debounce FSM, press/release/long-press strobes.
// Latency: a stable input change reaches pressed/press_pulse/release_pulse after DB_COUNT+3 edges.
// Backpressure: none; strobes are single-cycle and must be consumed when they occur.
module button_conditioner #(
    parameter int N_BUT      = 2,
    parameter int DB_COUNT   = 1000000,
    parameter int LONG_COUNT = 50000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BUT-1:0] but_n,
    output logic [N_BUT-1:0] pressed,
    output logic [N_BUT-1:0] press_pulse,
    output logic [N_BUT-1:0] release_pulse,
    output logic [N_BUT-1:0] long_pulse
);

    localparam int DB_W   = (DB_COUNT > 1) ? $clog2(DB_COUNT) : 1;
    localparam int HOLD_W = $clog2(LONG_COUNT + 1);

    // Terminal values sized to their counters so the compares stay width-exact
    localparam logic [DB_W-1:0]   DB_MAX      = DB_W'(DB_COUNT - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX    = HOLD_W'(LONG_COUNT);
    localparam logic [HOLD_W-1:0] HOLD_MAX_M1 = HOLD_W'(LONG_COUNT - 1);

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    for (genvar g = 0; g < N_BUT; g++) begin : g_chan
        logic              r_s1;
        logic              r_s2;
        state_t            r_state;
        logic [DB_W-1:0]   r_db_cnt;
        logic [HOLD_W-1:0] r_hold_cnt;
        logic              r_pressed;
        logic              r_press_pulse;
        logic              r_release_pulse;
        logic              r_long_pulse;
        logic              w_db_done;
        logic              w_hold_sat;
        logic              w_hold_hit;

        assign w_db_done  = (r_db_cnt == DB_MAX);
        assign w_hold_sat = (r_hold_cnt == HOLD_MAX);
        assign w_hold_hit = (r_hold_cnt == HOLD_MAX_M1);

        // Two-flop synchronizer on the raw async line; idles high (released)
        always_ff @(posedge clk) begin
            if (rst) begin
                r_s1 <= 1'b1;
                r_s2 <= 1'b1;
            end else begin
                r_s1 <= but_n[g];
                r_s2 <= r_s1;
            end
        end

        // Debounce FSM with hold counter; outputs are registered on the qualifying edge
        always_ff @(posedge clk) begin
            if (rst) begin
                r_state         <= RELEASED;
                r_db_cnt        <= '0;
                r_hold_cnt      <= '0;
                r_pressed       <= 1'b0;
                r_press_pulse   <= 1'b0;
                r_release_pulse <= 1'b0;
                r_long_pulse    <= 1'b0;
            end else begin
                r_press_pulse   <= 1'b0;
                r_release_pulse <= 1'b0;
                r_long_pulse    <= 1'b0;
                case (r_state)
                    RELEASED: begin
                        if (!r_s2) begin
                            r_state  <= PRESS_WAIT;
                            r_db_cnt <= '0;
                        end
                    end
                    PRESS_WAIT: begin
                        if (r_s2) begin
                            r_state  <= RELEASED;
                            r_db_cnt <= '0;
                        end else if (w_db_done) begin
                            r_state       <= HELD;
                            r_db_cnt      <= '0;
                            r_hold_cnt    <= '0;
                            r_pressed     <= 1'b1;
                            r_press_pulse <= 1'b1;
                        end else begin
                            r_db_cnt <= r_db_cnt + 1'b1;
                        end
                    end
                    HELD: begin
                        // Saturating hold count; the strobe fires only on the step into saturation
                        if (!w_hold_sat) begin
                            r_hold_cnt   <= r_hold_cnt + 1'b1;
                            r_long_pulse <= w_hold_hit;
                        end
                        if (r_s2) begin
                            r_state  <= RELEASE_WAIT;
                            r_db_cnt <= '0;
                        end
                    end
                    RELEASE_WAIT: begin
                        if (r_s2 && w_db_done) begin
                            // Release wins: a long strobe due on this edge is dropped
                            r_state         <= RELEASED;
                            r_db_cnt        <= '0;
                            r_pressed       <= 1'b0;
                            r_release_pulse <= 1'b1;
                        end else begin
                            if (!w_hold_sat) begin
                                r_hold_cnt   <= r_hold_cnt + 1'b1;
                                r_long_pulse <= w_hold_hit;
                            end
                            if (!r_s2) begin
                                r_state  <= HELD;
                                r_db_cnt <= '0;
                            end else begin
                                r_db_cnt <= r_db_cnt + 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state  <= RELEASED;
                        r_db_cnt <= '0;
                    end
                endcase
            end
        end

        assign pressed[g]       = r_pressed;
        assign press_pulse[g]   = r_press_pulse;
        assign release_pulse[g] = r_release_pulse;
        assign long_pulse[g]    = r_long_pulse;
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DB_COUNT=4, LONG_COUNT=10, N_BUT=2.
// Edge numbering: edge 1 is the first rising edge after an input change; outputs sampled #1 after each edge.
// Expected values are hand-derived from the debounce timing (qualify after edge 7, long after edge 17).
module tb_button_conditioner;

    localparam int N  = 2;
    localparam int DB = 4;
    localparam int LC = 10;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] but_n;
    logic [N-1:0] pressed;
    logic [N-1:0] press_pulse;
    logic [N-1:0] release_pulse;
    logic [N-1:0] long_pulse;

    int checks = 0;
    int errors = 0;

    button_conditioner #(
        .N_BUT     (N),
        .DB_COUNT  (DB),
        .LONG_COUNT(LC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .but_n        (but_n),
        .pressed      (pressed),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_pulse   (long_pulse)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [N-1:0] e_p, input logic [N-1:0] e_pp,
                           input logic [N-1:0] e_rp, input logic [N-1:0] e_lp);
        chk({tag, " pressed"}, pressed, e_p);
        chk({tag, " press_pulse"}, press_pulse, e_pp);
        chk({tag, " release_pulse"}, release_pulse, e_rp);
        chk({tag, " long_pulse"}, long_pulse, e_lp);
    endtask

    initial begin
        rst   = 1'b1;
        but_n = 2'b11;
        repeat (3) tick();
        chk_all("reset", 2'b00, 2'b00, 2'b00, 2'b00);
        rst = 1'b0;
        repeat (2) tick();
        chk_all("idle", 2'b00, 2'b00, 2'b00, 2'b00);

        // Clean press on channel 0: qualifies after edge 7
        but_n = 2'b10;
        for (int e = 1; e <= 8; e++) begin
            tick();
            chk_all($sformatf("press0 e%0d", e), (e >= 7) ? 2'b01 : 2'b00,
                    (e == 7) ? 2'b01 : 2'b00, 2'b00, 2'b00);
        end

        // Two-cycle high glitch while held: no change; hold count (1 at start) hits 10 at e9
        for (int e = 1; e <= 10; e++) begin
            if (e == 1) but_n[0] = 1'b1;
            if (e == 3) but_n[0] = 1'b0;
            tick();
            chk_all($sformatf("glitch0 e%0d", e), 2'b01, 2'b00, 2'b00,
                    (e == 9) ? 2'b01 : 2'b00);
        end

        // Release channel 0: qualifies after edge 7 of the release
        but_n[0] = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            chk_all($sformatf("rel0 e%0d", e), (e < 7) ? 2'b01 : 2'b00, 2'b00,
                    (e == 7) ? 2'b01 : 2'b00, 2'b00);
        end
        repeat (3) tick();

        // Long press on channel 1: press at e7, single long strobe at e17
        but_n = 2'b01;
        for (int e = 1; e <= 30; e++) begin
            tick();
            chk_all($sformatf("long1 e%0d", e), (e >= 7) ? 2'b10 : 2'b00,
                    (e == 7) ? 2'b10 : 2'b00, 2'b00, (e == 17) ? 2'b10 : 2'b00);
        end
        but_n = 2'b11;
        for (int e = 1; e <= 8; e++) begin
            tick();
            chk_all($sformatf("rel1 e%0d", e), (e < 7) ? 2'b10 : 2'b00, 2'b00,
                    (e == 7) ? 2'b10 : 2'b00, 2'b00);
        end
        repeat (3) tick();

        // Bounce: low 3, high 1, then low; final fall before e5 -> press after e11
        for (int e = 1; e <= 12; e++) begin
            but_n[0] = (e == 4) ? 1'b1 : 1'b0;
            tick();
            chk_all($sformatf("bounce0 e%0d", e), (e >= 11) ? 2'b01 : 2'b00,
                    (e == 11) ? 2'b01 : 2'b00, 2'b00, 2'b00);
        end
        but_n = 2'b11;
        for (int e = 1; e <= 8; e++) begin
            tick();
            chk_all($sformatf("relb0 e%0d", e), (e < 7) ? 2'b01 : 2'b00, 2'b00,
                    (e == 7) ? 2'b01 : 2'b00, 2'b00);
        end
        repeat (3) tick();

        // Release qualifying on the long-press edge (e17): release only, no long strobe
        but_n = 2'b10;
        for (int e = 1; e <= 19; e++) begin
            if (e == 11) but_n[0] = 1'b1;
            tick();
            chk_all($sformatf("suppress0 e%0d", e), (e >= 7 && e < 17) ? 2'b01 : 2'b00,
                    (e == 7) ? 2'b01 : 2'b00, (e == 17) ? 2'b01 : 2'b00, 2'b00);
        end
        repeat (3) tick();

        // Reset during PRESS_WAIT: nothing emitted, held button re-qualifies 7 edges later
        but_n = 2'b10;
        for (int e = 1; e <= 5; e++) begin
            tick();
            chk_all($sformatf("pw0 e%0d", e), 2'b00, 2'b00, 2'b00, 2'b00);
        end
        rst = 1'b1;
        tick();
        chk_all("rst_pw", 2'b00, 2'b00, 2'b00, 2'b00);
        rst = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            chk_all($sformatf("after_rst e%0d", e), (e >= 7) ? 2'b01 : 2'b00,
                    (e == 7) ? 2'b01 : 2'b00, 2'b00, 2'b00);
        end

        // Reset while held: pressed drops with no release strobe, then re-press
        rst = 1'b1;
        tick();
        chk_all("rst_held", 2'b00, 2'b00, 2'b00, 2'b00);
        rst = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            tick();
            chk_all($sformatf("after_rst2 e%0d", e), (e >= 7) ? 2'b01 : 2'b00,
                    (e == 7) ? 2'b01 : 2'b00, 2'b00, 2'b00);
        end
        but_n = 2'b11;
        for (int e = 1; e <= 8; e++) begin
            tick();
            chk_all($sformatf("relr0 e%0d", e), (e < 7) ? 2'b01 : 2'b00, 2'b00,
                    (e == 7) ? 2'b01 : 2'b00, 2'b00);
        end
        repeat (3) tick();

        // Simultaneous press and release on both channels
        but_n = 2'b00;
        for (int e = 1; e <= 8; e++) begin
            tick();
            chk_all($sformatf("both_press e%0d", e), (e >= 7) ? 2'b11 : 2'b00,
                    (e == 7) ? 2'b11 : 2'b00, 2'b00, 2'b00);
        end
        but_n = 2'b11;
        for (int e = 1; e <= 8; e++) begin
            tick();
            chk_all($sformatf("both_rel e%0d", e), (e < 7) ? 2'b11 : 2'b00, 2'b00,
                    (e == 7) ? 2'b11 : 2'b00, 2'b00);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
